if_id_skid_reg: RTL and testbench

Parametrised IF→ID pipeline stage register with a valid/ready handshake on both sides and a 2-entry skid buffer. Upstream may present a new PC/instruction every cycle without combinational ready paths from ID. Freeze (stall) and flush (squash) keep the team's existing priority. A saturating stall counter supports performance debug. Sits between the fetch stage and the decode stage of the 5-stage pipeline.

---
 rtl/if_id_skid_reg_pkg.sv | 29 ++
 rtl/if_id_skid_reg_skid_buf2.sv | 92 +++++++++
 rtl/if_id_skid_reg.sv | 64 ++++++
 tb/tb_if_id_skid_reg.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/if_id_skid_reg_pkg.sv
// Shared IF/ID pipeline definitions: skid-buffer states, default NOP encoding
// and the fetch payload record.
package if_id_skid_reg_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_t;

  localparam logic [31:0] DEFAULT_NOP = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } if_id_t;

  function automatic logic [1:0] occ_of(skid_state_t s);
    logic [1:0] occ;
    occ = 2'd0;
    case (s)
      ST_ONE:  occ = 2'd1;
      ST_FULL: occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/if_id_skid_reg_skid_buf2.sv
// Generic 2-entry valid/ready skid buffer with flush and hold. The head entry
// is registered and drives the outputs; the skid entry absorbs one extra beat.
module skid_buf2 #(
  parameter int unsigned    W         = 64,
  parameter logic [W-1:0]   EMPTY_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         hold,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   count
);
  import if_id_skid_reg_pkg::*;

  skid_state_t  state, state_nxt;
  logic [W-1:0] main_q, main_nxt;
  logic [W-1:0] skid_q, skid_nxt;
  logic         accept, deliver;

  // Ready is a function of local state and the stage controls only.
  assign in_ready = ~rst & ~hold & ~flush & (state != ST_FULL);
  assign accept   = in_valid & in_ready;
  assign deliver  = out_valid & out_ready & ~hold & ~flush;
  assign out_data = main_q;

  always_comb begin
    state_nxt = state;
    main_nxt  = main_q;
    skid_nxt  = skid_q;
    if (flush) begin
      state_nxt = ST_EMPTY;
      main_nxt  = EMPTY_VAL;
      skid_nxt  = EMPTY_VAL;
    end else if (!hold) begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            state_nxt = ST_ONE;
            main_nxt  = in_data;
          end
        end
        ST_ONE: begin
          if (accept && deliver) begin
            main_nxt = in_data;
          end else if (accept) begin
            state_nxt = ST_FULL;
            skid_nxt  = in_data;
          end else if (deliver) begin
            state_nxt = ST_EMPTY;
            main_nxt  = EMPTY_VAL;
          end
        end
        ST_FULL: begin
          // Head leaves first; the skid beat moves up so order stays FIFO.
          if (deliver) begin
            state_nxt = ST_ONE;
            main_nxt  = skid_q;
            skid_nxt  = EMPTY_VAL;
          end
        end
        default: begin
          state_nxt = ST_EMPTY;
          main_nxt  = EMPTY_VAL;
          skid_nxt  = EMPTY_VAL;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_EMPTY;
      main_q    <= EMPTY_VAL;
      skid_q    <= EMPTY_VAL;
      out_valid <= 1'b0;
      count     <= 2'd0;
    end else begin
      state     <= state_nxt;
      main_q    <= main_nxt;
      skid_q    <= skid_nxt;
      out_valid <= (state_nxt != ST_EMPTY);
      count     <= occ_of(state_nxt);
    end
  end

endmodule

// File: rtl/if_id_skid_reg.sv
// IF->ID stage register: skid buffer carrying {pc, inst}, NOP/zero when empty,
// plus a saturating stall counter for performance debug.
module if_id_skid_reg
  import if_id_skid_reg_pkg::*;
#(
  parameter int unsigned         PC_W     = 32,
  parameter int unsigned         INST_W   = 32,
  parameter logic [INST_W-1:0]   NOP_INST = INST_W'(DEFAULT_NOP),
  parameter int unsigned         CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   pc_in,
  input  logic [INST_W-1:0] inst_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   pc_out,
  output logic [INST_W-1:0] inst_out,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int unsigned  W         = PC_W + INST_W;
  localparam logic [W-1:0] EMPTY_VAL = {{PC_W{1'b0}}, NOP_INST};

  logic [W-1:0] payload;
  logic         stalled;

  skid_buf2 #(
    .W         (W),
    .EMPTY_VAL (EMPTY_VAL)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .hold      (freeze),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({pc_in, inst_in}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (payload),
    .count     (occupancy)
  );

  assign pc_out   = payload[W-1 -: PC_W];
  assign inst_out = payload[INST_W-1:0];

  // A stalled cycle is ID backpressure on a live entry or a frozen pipeline.
  assign stalled = (out_valid & ~out_ready) | freeze;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stalled && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Self-checking bench for if_id_skid_reg: a table of directed vectors plus
// hand-written sequences for counter saturation and asynchronous reset.
module tb_if_id_skid_reg;
  import if_id_skid_reg_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic        iv;
    logic [31:0] pc;
    logic        ordy;
    logic        frz;
    logic        fl;
    logic        exp_ir;
    logic        exp_ov;
    logic [31:0] exp_pc;
    logic [1:0]  exp_occ;
    int          exp_stall;
  } vec_t;

  logic        clk, rst, freeze, flush, in_valid, out_ready;
  logic [31:0] pc_in, inst_in;
  logic        in_ready, out_valid;
  logic [31:0] pc_out, inst_out;
  logic [1:0]  occupancy;
  logic [15:0] stall_cnt;
  logic        sat_in_ready, sat_out_valid;
  logic [31:0] sat_pc_out, sat_inst_out;
  logic [1:0]  sat_occupancy;
  logic [3:0]  sat_stall_cnt;

  int vec_cnt  = 0;
  int miss_cnt = 0;
  vec_t vecs[36];

  if_id_skid_reg #(.NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .pc_in(pc_in), .inst_in(inst_in),
    .out_valid(out_valid), .out_ready(out_ready), .pc_out(pc_out),
    .inst_out(inst_out), .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  if_id_skid_reg #(.NOP_INST(NOP), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .in_valid(in_valid), .in_ready(sat_in_ready), .pc_in(pc_in), .inst_in(inst_in),
    .out_valid(sat_out_valid), .out_ready(out_ready), .pc_out(sat_pc_out),
    .inst_out(sat_inst_out), .occupancy(sat_occupancy), .stall_cnt(sat_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {16'hC0DE, pc[15:0]};
  endfunction

  function automatic vec_t mk(input logic iv, input logic [31:0] pc, input logic ordy,
                              input logic frz, input logic fl, input logic ir,
                              input logic ov, input logic [31:0] epc,
                              input logic [1:0] occ, input int stall);
    vec_t v;
    v.iv = iv; v.pc = pc; v.ordy = ordy; v.frz = frz; v.fl = fl;
    v.exp_ir = ir; v.exp_ov = ov; v.exp_pc = epc; v.exp_occ = occ;
    v.exp_stall = stall;
    return v;
  endfunction

  function automatic int sat15(input int x);
    return (x > 15) ? 15 : x;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkState(input string tag, input logic ov, input logic [31:0] epc,
                            input logic [1:0] occ, input int stall);
    if_id_t exp_pl;
    exp_pl.pc   = ov ? epc : 32'h0;
    exp_pl.inst = ov ? inst_of(epc) : NOP;
    checkOutput({tag, ".out_valid"}, 64'(out_valid), 64'(ov));
    checkOutput({tag, ".payload"}, {pc_out, inst_out}, 64'(exp_pl));
    checkOutput({tag, ".occupancy"}, 64'(occupancy), 64'(occ));
    checkOutput({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(stall));
    checkOutput({tag, ".sat_stall_cnt"}, 64'(sat_stall_cnt), 64'(sat15(stall)));
  endtask

  task automatic drive(input logic iv, input logic [31:0] pc, input logic ordy,
                       input logic frz, input logic fl);
    in_valid  = iv;
    pc_in     = pc;
    inst_in   = inst_of(pc);
    out_ready = ordy;
    freeze    = frz;
    flush     = fl;
  endtask

  task automatic applyStimulus(input string tag, input vec_t v);
    @(negedge clk);
    drive(v.iv, v.pc, v.ordy, v.frz, v.fl);
    #1;
    checkOutput({tag, ".in_ready"}, 64'(in_ready), 64'(v.exp_ir));
    @(posedge clk);
    #1;
    checkState(tag, v.exp_ov, v.exp_pc, v.exp_occ, v.exp_stall);
  endtask

  initial begin
    // Streaming, then backpressure, freeze and flush segments.
    for (int i = 0; i < 16; i++)
      vecs[i] = mk(1, 32'(i * 4), 1, 0, 0, 1, 1, 32'(i * 4), 2'd1, 0);
    vecs[16] = mk(0, 32'h00, 1, 0, 0, 1, 0, 32'h00, 2'd0, 0);
    vecs[17] = mk(1, 32'h10, 0, 0, 0, 1, 1, 32'h10, 2'd1, 0);
    vecs[18] = mk(1, 32'h14, 0, 0, 0, 1, 1, 32'h10, 2'd2, 1);
    vecs[19] = mk(1, 32'h18, 0, 0, 0, 0, 1, 32'h10, 2'd2, 2);
    vecs[20] = mk(0, 32'h00, 1, 0, 0, 0, 1, 32'h14, 2'd1, 2);
    vecs[21] = mk(0, 32'h00, 1, 0, 0, 1, 0, 32'h00, 2'd0, 2);
    vecs[22] = mk(1, 32'h20, 0, 0, 0, 1, 1, 32'h20, 2'd1, 2);
    vecs[23] = mk(1, 32'h24, 0, 0, 0, 1, 1, 32'h20, 2'd2, 3);
    vecs[24] = mk(1, 32'h28, 1, 1, 0, 0, 1, 32'h20, 2'd2, 4);
    vecs[25] = mk(1, 32'h28, 1, 1, 0, 0, 1, 32'h20, 2'd2, 5);
    vecs[26] = mk(1, 32'h28, 1, 1, 0, 0, 1, 32'h20, 2'd2, 6);
    vecs[27] = mk(0, 32'h00, 1, 0, 0, 0, 1, 32'h24, 2'd1, 6);
    vecs[28] = mk(1, 32'h28, 0, 0, 0, 1, 1, 32'h24, 2'd2, 7);
    vecs[29] = mk(1, 32'h40, 0, 1, 1, 0, 0, 32'h00, 2'd0, 8);
    vecs[30] = mk(1, 32'h44, 0, 0, 0, 1, 1, 32'h44, 2'd1, 8);
    vecs[31] = mk(0, 32'h00, 1, 0, 0, 1, 0, 32'h00, 2'd0, 8);
    vecs[32] = mk(1, 32'h48, 1, 0, 0, 1, 1, 32'h48, 2'd1, 8);
    vecs[33] = mk(1, 32'h4C, 1, 0, 1, 0, 0, 32'h00, 2'd0, 8);
    vecs[34] = mk(1, 32'h50, 1, 0, 0, 1, 1, 32'h50, 2'd1, 8);
    vecs[35] = mk(0, 32'h00, 1, 0, 0, 1, 0, 32'h00, 2'd0, 8);

    rst = 1'b1;
    drive(1, 32'h0, 0, 0, 0);
    #1;
    checkOutput("reset.in_ready", 64'(in_ready), 64'd0);
    checkState("reset", 0, 32'h0, 2'd0, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 36; i++)
      applyStimulus($sformatf("vec%0d", i), vecs[i]);

    // Twenty frozen cycles while empty: wide counter climbs, narrow one pins at 15.
    for (int i = 1; i <= 20; i++)
      applyStimulus($sformatf("sat%0d", i),
                    mk(0, 32'h0, 0, 1, 0, 0, 0, 32'h0, 2'd0, 8 + i));
    applyStimulus("sat_hold", mk(0, 32'h0, 0, 0, 0, 1, 0, 32'h0, 2'd0, 28));

    // Fill both entries, then hit reset asynchronously mid-cycle.
    applyStimulus("rfull0", mk(1, 32'h4, 0, 0, 0, 1, 1, 32'h4, 2'd1, 28));
    applyStimulus("rfull1", mk(1, 32'h8, 0, 0, 0, 1, 1, 32'h4, 2'd2, 29));
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst.in_ready", 64'(in_ready), 64'd0);
    checkState("async_rst", 0, 32'h0, 2'd0, 0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus("post_rst0", mk(1, 32'hC, 1, 0, 0, 1, 1, 32'hC, 2'd1, 0));
    applyStimulus("post_rst1", mk(0, 32'h0, 1, 0, 0, 1, 0, 32'h0, 2'd0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
